// File: rtl/icache_pkg.sv
// Shared constants and types for the instruction-cache data store.
package icache_pkg;

    localparam int ICACHE_ADDR_WIDTH = 10;
    localparam int ICACHE_DATA_WIDTH = 32;
    localparam int ICACHE_DEPTH      = 1024;

    typedef logic [31:0] icache_word_t;

endpackage : icache_pkg

// File: rtl/icache_ins1_mem.sv
// Simple dual-port storage array: one write port, one registered read-first
// read port. The array itself is never reset so it maps onto block RAM; only
// the read-data register is cleared by rst_n.
module icache_ins1_mem
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
    parameter int DATA_WIDTH = ICACHE_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port; writes are dropped while reset is held so a controller
    // glitching during reset cannot corrupt preserved contents.
    always_ff @(posedge clk) begin
        if (wr_en && rst_n) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read port; sampling the array in the same edge as the write
    // gives read-first behaviour on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem_q[rd_addr];
        end
    end

endmodule : icache_ins1_mem

// File: rtl/icache_ins1.sv
// Instruction-cache data store top: 1024x32 simple dual-port RAM with
// registered, reset-cleared read data.
// Optional: define ICACHE_INS1_OUTREG_EN to add a second output register
// stage (read latency 2 instead of 1).
module icache_ins1
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
    parameter int DATA_WIDTH = ICACHE_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] ram_rd_q;

    icache_ins1_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_q    (ram_rd_q)
    );

`ifdef ICACHE_INS1_OUTREG_EN
    logic [DATA_WIDTH-1:0] out_q;

    // Extra retiming stage after the RAM read register, cleared with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= ram_rd_q;
        end
    end

    assign rd_data = out_q;
`else
    assign rd_data = ram_rd_q;
`endif

endmodule : icache_ins1

// File: tb/tb_icache_ins1.sv
// Self-checking bench for icache_ins1. Honors ICACHE_INS1_OUTREG_EN.
module tb_icache_ins1;
    import icache_pkg::*;

`ifdef ICACHE_INS1_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         wr_en = 1'b0;
    logic [9:0]   wr_addr = '0;
    icache_word_t wr_data = '0;
    logic [9:0]   rd_addr = '0;
    icache_word_t rd_data;

    int n_chk = 0;
    int n_err = 0;

    icache_ins1 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input icache_word_t act, input icache_word_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an associative word store plus an LAT-deep delay line
    // of expected output words (with a flag saying whether the word is known).
    icache_word_t mdl_mem [1024];
    bit           mdl_ok  [1024];
    icache_word_t dly_val [LAT];
    bit           dly_ok  [LAT];

    initial begin
        for (int i = 0; i < 1024; i++) mdl_ok[i] = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            dly_val[i] = '0;
            dly_ok[i]  = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                dly_val[i] = '0;
                dly_ok[i]  = 1'b1;
            end
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                dly_val[i] = dly_val[i-1];
                dly_ok[i]  = dly_ok[i-1];
            end
            dly_val[0] = mdl_mem[rd_addr];
            dly_ok[0]  = mdl_ok[rd_addr];
            if (wr_en) begin
                mdl_mem[wr_addr] = wr_data;
                mdl_ok[wr_addr]  = 1'b1;
            end
        end
    end

    // Compare DUT against model every cycle where the expected word is known.
    always @(negedge clk) begin
        if (dly_ok[LAT-1]) chk("model", rd_data, dly_val[LAT-1]);
    end

    // One clock of stimulus; inputs change 1 time unit after the edge.
    task automatic cyc(input bit we, input int wa, input icache_word_t wd, input int ra);
        wr_en   = we;
        wr_addr = wa[9:0];
        wr_data = wd;
        rd_addr = ra[9:0];
        @(posedge clk);
        #1;
    endtask

    task automatic read_lit(input int a, input icache_word_t exp, input string name);
        cyc(1'b0, 0, '0, a);
        for (int k = 1; k < LAT; k++) cyc(1'b0, 0, '0, a);
        chk(name, rd_data, exp);
    endtask

    initial begin
        // Reset: immediate clear on assertion, held for 20 cycles.
        #2 rst_n = 1'b0;
        #1 chk("reset_assert", rd_data, 32'h0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 0, '0, i);
            if (i == 0 || i == 19) chk("reset_hold", rd_data, 32'h0);
        end
        rst_n = 1'b1;

        // Fill every word with its complement-of-address pattern.
        for (int a = 0; a < 1024; a++) cyc(1'b1, a, 32'hFFFF_FFFF - a, 0);

        // Streamed readback, one address per cycle.
        for (int a = 0; a < 1024 + LAT - 1; a++) begin
            cyc(1'b0, 0, '0, (a < 1024) ? a : 0);
            if (a >= LAT - 1) chk("stream", rd_data, 32'hFFFF_FFFF - (a - (LAT - 1)));
        end
        read_lit(0,    32'hFFFF_FFFF, "lit_a0");
        read_lit(1023, 32'hFFFF_FC00, "lit_a1023");
        read_lit(512,  32'hFFFF_FDFF, "lit_a512");

        // Reset mid-stream: asynchronous clear, writes ignored while held.
        for (int a = 8; a < 12; a++) cyc(1'b0, 0, '0, a);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_async", rd_data, 32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 2, 32'h0000_0000, 3);
        chk("reset_mid_hold", rd_data, 32'h0);
        rst_n = 1'b1;
        read_lit(0, 32'hFFFF_FFFF, "post_reset_a0");
        read_lit(1, 32'hFFFF_FFFE, "post_reset_a1");
        read_lit(2, 32'hFFFF_FFFD, "post_reset_a2");
        read_lit(3, 32'hFFFF_FFFC, "post_reset_a3");

        // Write gating: wr_en low must leave address 7 untouched.
        cyc(1'b0, 7, 32'hDEAD_BEEF, 0);
        read_lit(7, 32'hFFFF_FFF8, "wr_gate");

        // Read-during-write to the same address returns old data.
        cyc(1'b1, 5, 32'h1234_5678, 0);
        cyc(1'b1, 5, 32'hCAFE_BABE, 5);
        for (int k = 1; k < LAT; k++) cyc(1'b0, 0, '0, 5);
        chk("rdw_old", rd_data, 32'h1234_5678);
        read_lit(5, 32'hCAFE_BABE, "rdw_new");

        // Address boundaries: no aliasing between top and bottom word.
        cyc(1'b1, 1023, 32'hA5A5_A5A5, 0);
        cyc(1'b1, 0,    32'h5A5A_5A5A, 0);
        read_lit(1023, 32'hA5A5_A5A5, "bound_hi");
        read_lit(0,    32'h5A5A_5A5A, "bound_lo");
        read_lit(1,    32'hFFFF_FFFE, "bound_a1");
        read_lit(1022, 32'hFFFF_FC01, "bound_a1022");

        cyc(1'b0, 0, '0, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_icache_ins1
